// File: rtl/seq_bit_serializer_pkg.sv
// Shared types and constants for the serializer that feeds the 1011 sequence detector.
package seq_pkg;
    typedef enum logic [1:0] {IDLE, SHIFT, GAP} ser_state_t;

    localparam int SEQ_WORD_W  = 8;
    localparam int SEQ_GAP_MAX = 15;
endpackage

// File: rtl/seq_bit_serializer.sv
// Parallel-to-serial front end: valid/ready word input, one bit per clock on x,
// one-word holding register for bubble-free streaming, optional inter-word gap.
module seq_bit_serializer
    import seq_pkg::ser_state_t;
    import seq_pkg::SEQ_WORD_W;
    import seq_pkg::SEQ_GAP_MAX;
#(
    parameter int WIDTH     = SEQ_WORD_W,
    parameter int MSB_FIRST = 1,
    parameter int GAP       = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             x,
    output logic             x_valid,
    output logic             busy,
    output logic             word_done
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int GW = $clog2(SEQ_GAP_MAX + 1);
    localparam logic [CW-1:0] LAST     = CW'(WIDTH - 1);
    localparam logic [GW-1:0] GAP_LOAD = GW'((GAP > 0) ? GAP - 1 : 0);

    ser_state_t       state, state_n;
    logic [WIDTH-1:0] sreg, sreg_n, shifted;
    logic [WIDTH-1:0] hold, hold_n;
    logic             hold_full, hold_full_n;
    logic [CW-1:0]    cnt, cnt_n;
    logic [GW-1:0]    gcnt, gcnt_n;
    logic             take, free_slot, consumed, head;

    assign take     = in_valid && in_ready;
    assign in_ready = !hold_full;

    // The register always moves toward whichever end is the head bit.
    assign shifted = (MSB_FIRST != 0) ? {sreg[WIDTH-2:0], 1'b0} : {1'b0, sreg[WIDTH-1:1]};
    assign head    = (MSB_FIRST != 0) ? sreg[WIDTH-1] : sreg[0];

    assign x_valid   = (state == seq_pkg::SHIFT);
    assign x         = x_valid && head;
    assign busy      = (state != seq_pkg::IDLE);
    assign word_done = x_valid && (cnt == LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= seq_pkg::IDLE;
            sreg      <= '0;
            hold      <= '0;
            hold_full <= 1'b0;
            cnt       <= '0;
            gcnt      <= '0;
        end else begin
            state     <= state_n;
            sreg      <= sreg_n;
            hold      <= hold_n;
            hold_full <= hold_full_n;
            cnt       <= cnt_n;
            gcnt      <= gcnt_n;
        end
    end

    always_comb begin
        state_n     = state;
        sreg_n      = sreg;
        hold_n      = hold;
        hold_full_n = hold_full;
        cnt_n       = cnt;
        gcnt_n      = gcnt;
        free_slot   = 1'b0;
        consumed    = 1'b0;

        case (state)
            seq_pkg::IDLE: begin
                if (take) begin
                    sreg_n   = in_data;
                    cnt_n    = '0;
                    state_n  = seq_pkg::SHIFT;
                    consumed = 1'b1;
                end
            end
            seq_pkg::SHIFT: begin
                sreg_n = shifted;
                cnt_n  = cnt + 1'b1;
                if (cnt == LAST) begin
                    if (GAP > 0) begin
                        state_n = seq_pkg::GAP;
                        gcnt_n  = GAP_LOAD;
                    end else begin
                        free_slot = 1'b1;
                    end
                end
            end
            seq_pkg::GAP: begin
                if (gcnt == '0) free_slot = 1'b1;
                else            gcnt_n    = gcnt - 1'b1;
            end
            default: state_n = seq_pkg::IDLE;
        endcase

        // A pending held word always wins the slot; in_ready is low then, so no
        // new handshake can compete with it.
        if (free_slot) begin
            if (hold_full) begin
                sreg_n      = hold;
                hold_full_n = 1'b0;
                cnt_n       = '0;
                state_n     = seq_pkg::SHIFT;
            end else if (take) begin
                sreg_n   = in_data;
                cnt_n    = '0;
                state_n  = seq_pkg::SHIFT;
                consumed = 1'b1;
            end else begin
                state_n = seq_pkg::IDLE;
            end
        end

        if (take && !consumed) begin
            hold_n      = in_data;
            hold_full_n = 1'b1;
        end
    end

endmodule
